// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encoding,
// opcodes and the mux/ALU select encodings shared with ALU control.
package mips_pkg;

    localparam int unsigned OP_W = 6;
    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_J_EX     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ANDI_EX  = 4'd11,
        S_IMM_WB   = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RF  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG_A  = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_control_if;
    import mips_pkg::*;

    logic [OP_W-1:0] opcode;
    logic            jr;
    logic            zero;
    logic            mem_ready;

    logic            pc_write;
    logic            pc_write_cond;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [1:0]      pc_source;
    logic            illegal;
    logic [ST_W-1:0] state;

    // Effective PC load enable as seen by the datapath PC register.
    logic            pc_en;
    assign pc_en = pc_write | (pc_write_cond & zero);

    modport master (
        input  opcode, jr, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, state
    );

    modport slave (
        output opcode, jr, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal, state, pc_en
    );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and decodes Moore-style datapath controls from the current state.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PC_ALU;
        bus.illegal       = 1'b0;
        bus.state         = ST_W'(state_q);

        case (state_q)
            // IR and PC+4 only commit on the cycle memory actually returns the word.
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SH;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_J:         state_d = S_J_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ANDI:      state_d = S_ANDI_EX;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            // jr resolves here: register A goes straight to the PC, skipping writeback.
            S_RTYPE_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_RF;
                if (bus.jr) begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PC_REG_A;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_RTYPE_WB;
                end
            end
            S_RTYPE_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ_EX: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PC_ALUOUT;
                state_d           = S_FETCH;
            end
            S_J_EX: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PC_JUMP;
                state_d       = S_FETCH;
            end
            S_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = S_IMM_WB;
            end
            S_ANDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_AND;
                state_d       = S_IMM_WB;
            end
            S_IMM_WB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and full
// control-vector comparisons against hand-computed values.
module tb_multicycle_control;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector: pw pwc iord mr mw irw m2r rd rw asa _ asb _ aop _ psrc _ ill
    localparam logic [16:0] C_F_NR  = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] C_F_R   = 17'b1001010000_01_00_00_0;
    localparam logic [16:0] C_DEC   = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] C_ILL   = 17'b0000000000_11_00_00_1;
    localparam logic [16:0] C_MADR  = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] C_MRD   = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] C_MWB   = 17'b0000001010_00_00_00_0;
    localparam logic [16:0] C_MWR   = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] C_REX   = 17'b0000000001_00_10_00_0;
    localparam logic [16:0] C_REXJR = 17'b1000000001_00_10_11_0;
    localparam logic [16:0] C_RWB   = 17'b0000000110_00_00_00_0;
    localparam logic [16:0] C_BEQ   = 17'b0100000001_00_01_01_0;
    localparam logic [16:0] C_J     = 17'b1000000000_00_00_10_0;
    localparam logic [16:0] C_ADDI  = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] C_ANDI  = 17'b0000000001_10_11_00_0;
    localparam logic [16:0] C_IMMWB = 17'b0000000010_00_00_00_0;

    function automatic logic [16:0] ctl();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mem_ready = 1'b0; bus.opcode = 6'd0; bus.jr = 1'b0; bus.zero = 1'b0;
        #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", bus.state); else passes++;
        checks++; if (ctl() !== C_F_NR) $display("FAIL reset_ctl: got %b expected %b", ctl(), C_F_NR); else passes++;
        bus.mem_ready = 1'b1; #1;
        checks++; if (ctl() !== C_F_R) $display("FAIL reset_ctl_ready: got %b expected %b", ctl(), C_F_R); else passes++;
        cyc();
        checks++; if (bus.state !== 4'd0) $display("FAIL reset_hold_state: got %0d expected 0", bus.state); else passes++;
        reset = 1'b0; bus.mem_ready = 1'b0;
        cyc(); #1;
    endtask

    task automatic test_lw();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [16:0] cv [5] = '{C_F_R, C_DEC, C_MADR, C_MRD, C_MWB};
        bus.opcode = 6'd35;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = 1'b1; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL lw_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        cyc(); #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL lw_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    task automatic test_lw_stall();
        logic [3:0]  st  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [16:0] cv  [7] = '{C_F_R, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD, C_MWB};
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.opcode = 6'd35;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = rdy[i]; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL lw_stall_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL lw_stall_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        cyc(); bus.mem_ready = 1'b1; #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL lw_stall_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    task automatic test_sw_stall();
        logic [3:0]  st  [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic [16:0] cv  [5] = '{C_F_R, C_DEC, C_MADR, C_MWR, C_MWR};
        logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.opcode = 6'd43;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = rdy[i]; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL sw_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL sw_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        cyc(); bus.mem_ready = 1'b1; #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL sw_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [16:0] cv [4] = '{C_F_R, C_DEC, C_REX, C_RWB};
        bus.opcode = 6'd0; bus.jr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = 1'b1; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL rtype_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        cyc(); #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL rtype_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    task automatic test_jr();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd6};
        logic [16:0] cv [3] = '{C_F_R, C_DEC, C_REXJR};
        bus.opcode = 6'd0; bus.jr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = 1'b1; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL jr_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL jr_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        cyc(); #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL jr_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    // jr left high to show it has no effect outside RTYPE_EX.
    task automatic test_beq();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd8};
        logic [16:0] cv [3] = '{C_F_R, C_DEC, C_BEQ};
        bus.opcode = 6'd4; bus.jr = 1'b1; bus.zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = 1'b1; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL beq_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL beq_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        checks++; if (bus.pc_en !== 1'b1) $display("FAIL beq_pc_en: got %b expected 1", bus.pc_en); else passes++;
        bus.zero = 1'b0; #1;
        checks++; if (bus.pc_en !== 1'b0) $display("FAIL beq_pc_en_nz: got %b expected 0", bus.pc_en); else passes++;
        bus.jr = 1'b0;
        cyc(); #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL beq_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    task automatic test_j();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd9};
        logic [16:0] cv [3] = '{C_F_R, C_DEC, C_J};
        bus.opcode = 6'd2;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = 1'b1; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL j_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL j_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
        cyc(); #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL j_end_state: got %0d expected 0", bus.state); else passes++;
    endtask

    task automatic test_imm();
        logic [5:0]  ops [2] = '{6'd8, 6'd12};
        logic [3:0]  ex  [2] = '{4'd10, 4'd11};
        logic [16:0] exc [2] = '{C_ADDI, C_ANDI};
        for (int k = 0; k < 2; k++) begin
            bus.opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                logic [3:0]  es;
                logic [16:0] ec;
                es = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : (i == 2) ? ex[k] : 4'd12;
                ec = (i == 0) ? C_F_R : (i == 1) ? C_DEC : (i == 2) ? exc[k] : C_IMMWB;
                if (i > 0) cyc();
                bus.mem_ready = 1'b1; #1;
                checks++; if (bus.state !== es) $display("FAIL imm%0d_state[%0d]: got %0d expected %0d", ops[k], i, bus.state, es); else passes++;
                checks++; if (ctl() !== ec) $display("FAIL imm%0d_ctl[%0d]: got %b expected %b", ops[k], i, ctl(), ec); else passes++;
            end
            cyc(); #1;
            checks++; if (bus.state !== 4'd0) $display("FAIL imm%0d_end_state: got %0d expected 0", ops[k], bus.state); else passes++;
        end
    endtask

    // Two FETCH wait cycles, then an unsupported opcode.
    task automatic test_illegal();
        logic [3:0]  st  [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
        logic [16:0] cv  [5] = '{C_F_NR, C_F_NR, C_F_R, C_ILL, C_F_R};
        logic        rdy [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus.opcode = 6'd63;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = rdy[i]; #1;
            checks++; if (bus.state !== st[i]) $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
            checks++; if (ctl() !== cv[i]) $display("FAIL illegal_ctl[%0d]: got %b expected %b", i, ctl(), cv[i]); else passes++;
        end
    endtask

    task automatic test_reset_mid_memrd();
        logic [3:0] st [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        bus.opcode = 6'd35;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            bus.mem_ready = (i < 3); #1;
            checks++; if (bus.state !== st[i]) $display("FAIL rstmid_state[%0d]: got %0d expected %0d", i, bus.state, st[i]); else passes++;
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL rstmid_async_state: got %0d expected 0", bus.state); else passes++;
        checks++; if (ctl() !== C_F_NR) $display("FAIL rstmid_ctl: got %b expected %b", ctl(), C_F_NR); else passes++;
        cyc();
        checks++; if (bus.state !== 4'd0) $display("FAIL rstmid_hold_state: got %0d expected 0", bus.state); else passes++;
        reset = 1'b0;
        cyc(); #1;
        checks++; if (bus.state !== 4'd0) $display("FAIL rstmid_after_state: got %0d expected 0", bus.state); else passes++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lw_stall();
        test_sw_stall();
        test_rtype();
        test_jr();
        test_beq();
        test_j();
        test_imm();
        test_illegal();
        test_reset_mid_memrd();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU control decoder. Each cycle it sequences instruction fetch, decode, execute, memory and writeback, and drives the datapath mux/enable signals plus the 2-bit `alu_op` consumed by ALU control. It consumes the `jr` flag returned by ALU control to redirect the PC. It stalls on a single-signal memory ready handshake.

## Interface
- `OP_W`, 6: opcode width.
- `ST_W`, 4: state encoding width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; forces FETCH.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `jr`  in  1  from ALU control; high when alu_op=10 and funct=8.
- `zero`  in  1  ALU zero flag (used only via pc_write_cond).
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls.
- `alu_src_b`  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- `alu_op`  out  2  00 add, 01 sub, 10 R-format, 11 and.
- `pc_source`  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  ST_W  current state (debug).

## Operation
- Moore FSM; all outputs decode combinationally from `state`, except those gated by `mem_ready` as noted. Any control not listed for a state is 0.
- **FETCH (0)**
  - Drives mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal `mem_ready`.
  - Stays in FETCH while `!mem_ready`; goes to DECODE on `mem_ready`.
- **DECODE (1)**
  - Drives alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 0 → RTYPE_EX
    - 35 or 43 → MEM_ADR
    - 4 → BEQ_EX
    - 2 → J_EX
    - 8 → ADDI_EX
    - 12 → ANDI_EX
    - any other opcode → FETCH, with `illegal`=1 in this cycle.
- **MEM_ADR (2)**: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD if opcode=35, else MEM_WR.
- **MEM_RD (3)**: i_or_d=1, mem_read=1. Holds until `mem_ready`, then MEM_WB.
- **MEM_WB (4)**: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- **MEM_WR (5)**: i_or_d=1, mem_write=1. Holds until `mem_ready`, then FETCH.
- **RTYPE_EX (6)**
  - Drives alu_src_a=1, alu_src_b=00, alu_op=10.
  - If `jr`: pc_write=1, pc_source=11, next FETCH.
  - Else next RTYPE_WB.
- **RTYPE_WB (7)**: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- **BEQ_EX (8)**: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- **J_EX (9)**: pc_write=1, pc_source=10. Next: FETCH.
- **ADDI_EX (10)**: alu_src_a=1, alu_src_b=10, alu_op=00. Next: IMM_WB.
- **ANDI_EX (11)**: alu_src_a=1, alu_src_b=10, alu_op=11. Next: IMM_WB.
- **IMM_WB (12)**: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Encodings 13–15 are unreachable. If ever entered: next FETCH, all controls 0.

## Timing
- Reset:
  - Asserting `reset` forces state=FETCH immediately (asynchronous).
  - While in reset, outputs are the FETCH set: mem_read=1, alu_src_b=01, everything else 0. pc_write and ir_write remain gated by `mem_ready`.
  - Reset asserted mid-instruction abandons the instruction. No write strobe is asserted after reset asserts.
- Cycles per instruction with `mem_ready` tied high:
  - lw 5
  - sw, R-type, addi, andi 4
  - beq, j, jr 3
  - illegal 2
- Each wait cycle with `mem_ready` low adds exactly one cycle in FETCH, MEM_RD or MEM_WR.
- During a wait cycle, mem_read/mem_write stay asserted and address controls stay stable.
- `mem_ready` has no effect in any other state.
- `jr` is sampled only in RTYPE_EX. `opcode` is sampled only in DECODE and MEM_ADR.

## Structure
- Shared package `mips_pkg` holds:
  - State enum.
  - Opcode constants: RTYPE=0, J=2, BEQ=4, ADDI=8, ANDI=12, LW=35, SW=43.
  - alu_op codes 00/01/10/11, matching ALU control.
  - alu_src_b and pc_source encodings.
- Implementation is a single module with a sequential state register and combinational next-state/output logic. No sub-module.

## Test plan
- Reset mid-MEM_RD → state=0 immediately; mem_read=1, alu_src_b=01, reg_write=0.
- lw (35), mem_ready=1 → states 0,1,2,3,4; reg_write=1 with mem_to_reg=1 in cycle 5.
- lw with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_read and i_or_d held high throughout the stall.
- R-type, funct add, jr=0 → alu_op=10 in RTYPE_EX, then reg_write=1 with reg_dst=1. Same with jr=1 → pc_write=1, pc_source=11, back in FETCH after 3 cycles, no reg_write.
- beq (4) → BEQ_EX drives alu_op=01, pc_write_cond=1, pc_source=01. addi (8) and andi (12) → alu_op 00 and 11 respectively, then IMM_WB.
- opcode 63 → illegal=1 in DECODE for one cycle; next state FETCH; no write strobes asserted.
